// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state enum, geometry and key map for the keypad scanner
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} scan_state_t;
  localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    return KEY_TABLE[{row_idx, col_idx, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// sync2: parameterized-width two-flop synchronizer
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk) begin
    meta <= reset ? '0 : d;
    q    <= reset ? '0 : meta;
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with press/release debounce and one strobe per press
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] inputrows,
  output logic [NUM_COLS-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  logic [NUM_ROWS-1:0] rows_s;
  scan_state_t         state, state_n;
  logic [DW-1:0]       dwell, dwell_n;
  logic [BW-1:0]       deb, deb_n;
  logic [1:0]          col_idx, col_n, row_cap, row_cap_n, row_low;
  logic [3:0]          code_n;
  logic                valid_n, row_hit, dwell_last, deb_last;

  sync2 #(.W(NUM_ROWS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (inputrows),
    .q     (rows_s)
  );

  assign cols       = 4'b0001 << col_idx;
  assign key_held   = (state == HELD) || (state == RELEASE);
  assign row_hit    = rows_s[row_cap];
  assign dwell_last = dwell == DW'(SCAN_DIV - 1);
  assign deb_last   = deb == BW'(DEBOUNCE_CYCLES - 1);
  assign row_low    = rows_s[0] ? 2'd0 : rows_s[1] ? 2'd1 : rows_s[2] ? 2'd2 : 2'd3;

  always_comb begin
    state_n   = state;
    col_n     = col_idx;
    dwell_n   = '0;
    deb_n     = '0;
    row_cap_n = row_cap;
    code_n    = key_code;
    valid_n   = 1'b0;
    case (state)
      SCAN: begin
        if (!dwell_last) dwell_n = dwell + 1'b1;
        else if (|rows_s) begin
          state_n   = DEBOUNCE;
          row_cap_n = row_low;
        end else col_n = col_idx + 2'd1;
      end
      DEBOUNCE: begin
        if (!row_hit) begin
          state_n = SCAN;
          col_n   = col_idx + 2'd1;
        end else if (deb_last) begin
          state_n = HELD;
          code_n  = keymap(row_cap, col_idx);
          valid_n = 1'b1;
        end else deb_n = deb + 1'b1;
      end
      HELD: state_n = row_hit ? HELD : RELEASE;
      RELEASE: begin
        if (row_hit) state_n = HELD;
        else if (deb_last) begin
          state_n = SCAN;
          col_n   = col_idx + 2'd1;
        end else deb_n = deb + 1'b1;
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      dwell     <= '0;
      deb       <= '0;
      row_cap   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      dwell     <= dwell_n;
      deb       <= deb_n;
      row_cap   <= row_cap_n;
      key_code  <= code_n;
      key_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed table-driven bench with a physical keypad model
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] inputrows, cols, key_code;
  logic       key_valid, key_held;
  logic [3:0] pressed [4];
  int         errors = 0, checks = 0, strobes = 0;
  logic [3:0] last_code = '0;

  typedef struct {
    int         col;
    logic [3:0] rows;
    logic [3:0] code;
  } vec_t;
  vec_t vecs [9];

  keypad_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .inputrows (inputrows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    inputrows = '0;
    for (int c = 0; c < 4; c++) inputrows |= cols[c] ? pressed[c] : 4'b0000;
  end

  always @(posedge clk) if (key_valid) begin
    strobes++;
    last_code = key_code;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_col(input int col);
    for (int i = 0; i < 100 && cols !== (4'b0001 << col); i++) @(negedge clk);
  endtask

  task automatic press_key(input int col, input logic [3:0] rows, input logic [3:0] code);
    int s0;
    wait_col(col);
    s0 = strobes;
    pressed[col] = rows;
    repeat (80) @(negedge clk);
    chk("press strobe count", strobes - s0, 1);
    chk("press strobe code", last_code, code);
    chk("press key_code", key_code, code);
    chk("press key_held", key_held, 1);
    chk("press cols frozen", cols, 4'b0001 << col);
  endtask

  task automatic release_key(input int col);
    int s0;
    s0 = strobes;
    pressed[col] = '0;
    repeat (16) @(negedge clk);
    chk("release held early", key_held, 1);
    for (int i = 0; i < 40 && key_held; i++) @(negedge clk);
    chk("release held fall", key_held, 0);
    chk("release cols advance", cols, 4'b0001 << ((col + 1) % 4));
    chk("release no strobe", strobes - s0, 0);
  endtask

  initial begin
    int s0, low_cnt;
    vecs[0] = '{0, 4'b0100, 4'h7};
    vecs[1] = '{3, 4'b1000, 4'hD};
    vecs[2] = '{2, 4'b1010, 4'h6};
    vecs[3] = '{1, 4'b1000, 4'h0};
    vecs[4] = '{0, 4'b0001, 4'h1};
    vecs[5] = '{3, 4'b0010, 4'hB};
    vecs[6] = '{2, 4'b0100, 4'h9};
    vecs[7] = '{0, 4'b1000, 4'hE};
    vecs[8] = '{2, 4'b1000, 4'hF};
    for (int c = 0; c < 4; c++) pressed[c] = '0;
    repeat (10) @(negedge clk);
    chk("reset cols", cols, 4'b0001);
    chk("reset key_valid", key_valid, 0);
    chk("reset key_held", key_held, 0);
    chk("reset key_code", key_code, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rotation", cols, 4'b0001 << (k % 4));
      repeat (8) @(negedge clk);
    end
    chk("no strobe while idle", strobes, 0);
    for (int v = 0; v < 9; v++) begin
      press_key(vecs[v].col, vecs[v].rows, vecs[v].code);
      release_key(vecs[v].col);
    end
    wait_col(1);
    s0 = strobes;
    for (int i = 0; i < 40; i++) begin
      pressed[1] = ((i / 3) % 2 == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
    end
    chk("bounce no strobe", strobes - s0, 0);
    press_key(1, 4'b0001, 4'h2);
    release_key(1);
    press_key(3, 4'b1000, 4'hD);
    s0 = strobes;
    low_cnt = 0;
    pressed[3] = '0;
    repeat (5) @(negedge clk);
    pressed[3] = 4'b1000;
    repeat (30) begin
      @(negedge clk);
      if (!key_held) low_cnt++;
    end
    chk("release bounce held low cycles", low_cnt, 0);
    chk("release bounce no strobe", strobes - s0, 0);
    release_key(3);
    press_key(2, 4'b1010, 4'h6);
    s0 = strobes;
    pressed[0] = 4'b0001;
    repeat (40) @(negedge clk);
    chk("other column ignored", strobes - s0, 0);
    chk("other column cols frozen", cols, 4'b0100);
    pressed[0] = '0;
    release_key(2);
    for (int i = 0; i < 100 && cols === 4'b0001; i++) @(negedge clk);
    wait_col(0);
    s0 = strobes;
    pressed[0] = 4'b0001;
    repeat (16) @(negedge clk);
    chk("mid-debounce captured", cols, 4'b0001);
    reset = 1'b1;
    @(negedge clk);
    pressed[0] = '0;
    chk("mid reset cols", cols, 4'b0001);
    chk("mid reset held", key_held, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid reset no strobe", strobes - s0, 0);
    chk("mid reset key_code", key_code, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 hex keypad. Drives the column lines one-hot, samples and synchronizes the row lines, and debounces presses and releases. Emits exactly one single-cycle `key_valid` strobe with a 4-bit hex code per physical press. Sits between the keypad pins and the two-digit display-history logic in the top level, which consumes `key_code`/`key_valid`.

## Interface
Parameters:
- `SCAN_DIV`, 24000: cycles each column is driven before advancing (1 ms at 24 MHz); must be >= 4.
- `DEBOUNCE_CYCLES`, 480000: consecutive stable cycles required to accept a press or a release (20 ms); must be >= 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `inputrows`  in  4: raw keypad row lines, active-high, asynchronous to `clk`.
- `cols`  out  4: one-hot column drive.
- `key_code`  out  4: hex value of the last accepted key; holds until the next accept.
- `key_valid`  out  1: one-cycle strobe, coincident with `key_code` update.
- `key_held`  out  1: high while a press is accepted and its release is not yet debounced.

## Operation
- `inputrows` passes through a 2-flop synchronizer, giving `rows_s`. All decisions use `rows_s` only.
- FSM states:
  - `SCAN`:
    - `cols` rotates 0001→0010→0100→1000→0001, advancing when the dwell counter hits `SCAN_DIV-1`.
    - On that same last-dwell cycle, if `rows_s != 0`: capture column index and the lowest-index set row into `row_cap`. Freeze `cols`, clear the debounce counter, and go to `DEBOUNCE`. `cols` does not advance.
  - `DEBOUNCE`:
    - Each cycle, if `rows_s[row_cap]` is 1, increment the counter. Otherwise return to `SCAN`; the column advances on the next cycle.
    - When the counter reaches `DEBOUNCE_CYCLES-1` with the row still high: go to `HELD`, load `key_code`, and pulse `key_valid`.
  - `HELD`:
    - `cols` stays frozen and `key_held` is 1.
    - When `rows_s[row_cap]` is 0, clear the counter and go to `RELEASE`.
    - Other rows going high are ignored.
  - `RELEASE`:
    - Counter increments while `rows_s[row_cap]` is 0.
    - If the row reasserts, return to `HELD`; no new strobe.
    - When the counter reaches `DEBOUNCE_CYCLES-1`, go to `SCAN`, set `key_held` to 0, and advance the column.
- Key map, by (row, col index):
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Multiple rows high at capture: the lowest row index wins. Multiple keys in other columns are never seen while frozen.

## Timing
- Reset values:
  - `cols`=0001, `key_code`=0, `key_valid`=0, `key_held`=0.
  - State `SCAN`; dwell and debounce counters 0; synchronizer flops 0.
- Reset asserted in any state returns to these values on the next edge. No strobe is emitted for a press in progress; the press must be re-detected from `SCAN`.
- Latency:
  - Row edge to `rows_s`: 2 cycles.
  - Capture to `key_valid`: `DEBOUNCE_CYCLES` cycles.
  - `key_valid` and `key_code` are registered outputs and update on the same edge.
- `key_held` rises on the same edge as `key_valid`. It falls on the edge leaving `RELEASE`.
- Counter widths are `$clog2` of the parameter. Counters saturate only by state exit and never wrap mid-state.
- Minimum repeat: a second strobe requires a full release debounce, then at least one `SCAN` detection.

## Structure
- Package `keypad_pkg`:
  - FSM state enum `scan_state_t` (`SCAN`, `DEBOUNCE`, `HELD`, `RELEASE`).
  - Key-map function `keymap(row_idx, col_idx)` returning 4 bits.
  - Localparams for row/column count (4).
- One sub-module: `sync2`, a parameterized-width 2-flop synchronizer, instantiated on `inputrows`.
- Everything else (dwell counter, debounce counter, FSM, output registers) lives in `keypad_scan_ctrl`.

## Test plan
All scenarios use `SCAN_DIV`=8 and `DEBOUNCE_CYCLES`=16.
- Reset: hold `reset` 10 cycles → `cols`=0001, `key_valid`=0, `key_held`=0, `key_code`=0. After release, `cols` advances every 8 cycles in the order 0001, 0010, 0100, 1000, 0001.
- Clean press: when `cols`=0001, drive `inputrows`=0100 for 200 cycles, then 0000 → exactly one `key_valid` pulse with `key_code`=7. `cols` stays frozen at 0001 while held. `key_held` falls 16+2 cycles after release, then scanning resumes.
- Bounce: when `cols`=0010, toggle `inputrows` 0001/0000 every 3 cycles for 40 cycles, then hold 0001 → no strobe during the toggling. One strobe with `key_code`=2 after a stable 16-cycle window.
- Release bounce: while `key_code`=D is held (row3, `cols`=1000), drop the row for 5 cycles, then reassert → no second strobe, and `key_held` stays 1.
- Simultaneous rows: at `cols`=0100, drive `inputrows`=1010 → `key_code`=6 (row1 wins). An added press on another column during `HELD` produces no strobe.
- Reset mid-debounce: assert `reset` 8 cycles after capture → `key_valid` never pulses, and `cols`=0001 on the cycle after reset.
